fpu_arbitro: RTL

//  Shares one floating-point adder/multiplier between two requesters.

---
 rtl/fpu_arbitro_if.sv | 22 ++
 rtl/fpu_arbitro.sv | 114 +++++++++++
 2 files changed

// File: rtl/fpu_arbitro_if.sv
// rtl/fpu_arbitro_if.sv - request/response channel bundle between two requesters and the FPU arbiter
interface fpu_arbitro_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/fpu_arbitro.sv
// rtl/fpu_arbitro.sv - round-robin sharing of one FPU between two requesters, one op in flight
module fpu_arbitro #(
    parameter int unsigned LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    fpu_arbitro_if.slave        bus,
    output logic [31:0]         Float_num_A,
    output logic [31:0]         Float_num_B,
    output logic                OP_input,
    input  logic [31:0]         Resultado,
    output logic                busy
);
    localparam int unsigned W = 32;

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("fpu_arbitro: LATENCY must be within 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           last_q, last_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           op_q, op_d;
    logic [W-1:0]   data_q, data_d;
    logic           id_q, id_d;

    logic           any_vld;
    logic           gnt_id;

    // With both requesters valid the one not granted last time wins.
    assign any_vld = |bus.req_valid;
    assign gnt_id  = bus.req_valid[1] & (~bus.req_valid[0] | ~last_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        data_d  = data_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    a_d     = gnt_id ? bus.req_a[63:32] : bus.req_a[31:0];
                    b_d     = gnt_id ? bus.req_b[63:32] : bus.req_b[31:0];
                    op_d    = bus.req_op[gnt_id];
                    id_d    = gnt_id;
                    last_d  = gnt_id;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    data_d  = Resultado;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            data_q  <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    // Ready is only offered from IDLE and is suppressed while reset is asserted.
    assign bus.req_ready = (state_q == IDLE && any_vld && !rst) ?
                           (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;
    assign Float_num_A   = a_q;
    assign Float_num_B   = b_q;
    assign OP_input      = op_q;
    assign busy          = (state_q != IDLE);
endmodule
